vga_ptngen_param: RTL and testbench

Parametrised VGA timing-plus-pattern generator that succeeds the separate sync and pattern generators in the display path. It runs on the pixel clock from `pckgen` and derives H/V timing from parameters. It produces one of eight test patterns at configurable colour depth, with optional per-frame horizontal scrolling. Pattern mode and scroll enable change only at frame boundaries, so mode switches never tear a frame.

---
 rtl/vga_ptngen_param.sv | 181 ++++++++++++++++++
 tb/tb_vga_ptngen_param.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_ptngen_param.sv
// Parametrised VGA timing and test-pattern generator. Counters feed a single registered
// output stage, so sync, enable, colour and frame pulse all trail the counters by one PCK.
module vga_ptngen_param #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int COLOR_W   = 8,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0
) (
    input  logic               PCK,
    input  logic               RST,
    input  logic [2:0]         MODE,
    input  logic               SCROLL_EN,
    output logic [9:0]         HCNT,
    output logic [9:0]         VCNT,
    output logic               VGA_DISPLAY_EN,
    output logic               VGA_HSYNC,
    output logic               VGA_VSYNC,
    output logic [COLOR_W-1:0] VGA_R,
    output logic [COLOR_W-1:0] VGA_G,
    output logic [COLOR_W-1:0] VGA_B,
    output logic               FRAME_START
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int BAR_W   = H_ACTIVE / 8;

    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  OFF_LAST = 10'(H_ACTIVE - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [COLOR_W-1:0] C_MAX = '1;

    logic [9:0]         hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [9:0]         offset_q, offset_d;
    logic [2:0]         mode_q, mode_d;
    logic               scroll_q, scroll_d;
    logic               frame_start;
    logic [10:0]        x_w, y_w, sum, xs;
    logic [2:0]         bar;
    logic               active, pix_on;
    logic               de_q, de_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
    logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;

    // NOTE: every variable gets a default at the top of each always_comb so no path can infer a latch.
    always_comb begin
        frame_start = (hcnt_q == 10'd0) && (vcnt_q == 10'd0);
        hcnt_d      = (hcnt_q == H_LAST) ? 10'd0 : hcnt_q + 10'd1;
        vcnt_d      = vcnt_q;
        if (hcnt_q == H_LAST) begin
            vcnt_d = (vcnt_q == V_LAST) ? 10'd0 : vcnt_q + 10'd1;
        end
        mode_d   = frame_start ? MODE : mode_q;
        scroll_d = frame_start ? SCROLL_EN : scroll_q;
        offset_d = offset_q;
        if (frame_start && scroll_q) begin
            offset_d = (offset_q == OFF_LAST) ? 10'd0 : offset_q + 10'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample the same pre-edge values.
    always_ff @(posedge PCK or posedge RST) begin
        if (RST) begin
            hcnt_q   <= 10'd0;
            vcnt_q   <= 10'd0;
            offset_q <= 10'd0;
            mode_q   <= 3'd0;
            scroll_q <= 1'b0;
        end else begin
            hcnt_q   <= hcnt_d;
            vcnt_q   <= vcnt_d;
            offset_q <= offset_d;
            mode_q   <= mode_d;
            scroll_q <= scroll_d;
        end
    end

    // The first pixel of a frame is rendered in the same cycle its mode/offset are latched,
    // so the pattern logic reads the next-state values rather than the registers.
    always_comb begin
        x_w    = {1'b0, hcnt_q};
        y_w    = {1'b0, vcnt_q};
        sum    = {1'b0, hcnt_q} + {1'b0, offset_d};
        xs     = (sum >= H_ACT) ? sum - H_ACT : sum;
        active = (x_w < H_ACT) && (y_w < V_ACT);
        bar    = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (xs >= 11'(k * BAR_W)) bar = bar + 3'd1;
        end

        pix_on = 1'b0;
        r_d    = '0;
        g_d    = '0;
        b_d    = '0;
        case (mode_d)
            3'd0: begin
                r_d = {COLOR_W{~bar[1]}};
                g_d = {COLOR_W{~bar[2]}};
                b_d = {COLOR_W{~bar[0]}};
            end
            3'd1: begin
                pix_on = ~(xs[5] ^ y_w[5]);
                r_d    = {COLOR_W{pix_on}};
                g_d    = {COLOR_W{pix_on}};
                b_d    = {COLOR_W{pix_on}};
            end
            3'd2: begin
                r_d = xs[COLOR_W-1:0];
                g_d = y_w[COLOR_W-1:0];
            end
            3'd3: begin
                pix_on = (xs[4:0] == 5'd0) || (y_w[4:0] == 5'd0) ||
                         (x_w == H_ACT - 11'd1) || (y_w == V_ACT - 11'd1);
                r_d    = {COLOR_W{pix_on}};
                g_d    = {COLOR_W{pix_on}};
                b_d    = {COLOR_W{pix_on}};
            end
            3'd4: r_d = C_MAX;
            3'd5: g_d = C_MAX;
            3'd6: b_d = C_MAX;
            default: begin
                r_d = C_MAX;
                g_d = C_MAX;
                b_d = C_MAX;
            end
        endcase
        if (!active) begin
            r_d = '0;
            g_d = '0;
            b_d = '0;
        end

        de_d = active;
        hs_d = ((x_w >= HS_START) && (x_w < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
        vs_d = ((y_w >= VS_START) && (y_w < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
        fs_d = frame_start;
    end

    always_ff @(posedge PCK or posedge RST) begin
        if (RST) begin
            de_q <= 1'b0;
            hs_q <= ~HSYNC_POL;
            vs_q <= ~VSYNC_POL;
            fs_q <= 1'b0;
            r_q  <= '0;
            g_q  <= '0;
            b_q  <= '0;
        end else begin
            de_q <= de_d;
            hs_q <= hs_d;
            vs_q <= vs_d;
            fs_q <= fs_d;
            r_q  <= r_d;
            g_q  <= g_d;
            b_q  <= b_d;
        end
    end

    assign HCNT           = hcnt_q;
    assign VCNT           = vcnt_q;
    assign VGA_DISPLAY_EN = de_q;
    assign VGA_HSYNC      = hs_q;
    assign VGA_VSYNC      = vs_q;
    assign VGA_R          = r_q;
    assign VGA_G          = g_q;
    assign VGA_B          = b_q;
    assign FRAME_START    = fs_q;

endmodule

// File: tb/tb_vga_ptngen_param.sv
// Bench for vga_ptngen_param: three differently parametrised instances checked every cycle
// against a frame-level arithmetic model, plus hand-computed pixel and timing expectations.
module tb_vga_ptngen_param;

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb, cw, hp, vp;
    } cfg_t;

    typedef struct {
        int de, hs, vs, fs, r, g, b;
    } exp_t;

    localparam int FT_A = 3840;  // 80 x 48

    logic       PCK;
    logic       RST;
    logic [2:0] mode_in [3];
    logic       scr_in  [3];

    logic [9:0] hc_a, vc_a, hc_b, vc_b, hc_c, vc_c;
    logic       de_a, hs_a, vs_a, fs_a, de_b, hs_b, vs_b, fs_b, de_c, hs_c, vs_c, fs_c;
    logic [7:0] r_a, g_a, b_a;
    logic [3:0] r_b, g_b, b_b;
    logic [2:0] r_c, g_c, b_c;

    cfg_t cfg [3];
    int   k [3];
    int   mode_h [3][256];
    int   scr_h  [3][256];
    int   off_h  [3][256];
    int   n_total = 0;
    int   n_bad   = 0;
    int   de_cnt  = 0;
    int   hs_cnt  = 0;
    int   vs_cnt  = 0;

    vga_ptngen_param #(
        .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(40), .V_FP(2), .V_SYNC(2), .V_BP(4),
        .COLOR_W(8), .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
    ) dut_a (
        .PCK(PCK), .RST(RST), .MODE(mode_in[0]), .SCROLL_EN(scr_in[0]),
        .HCNT(hc_a), .VCNT(vc_a), .VGA_DISPLAY_EN(de_a), .VGA_HSYNC(hs_a), .VGA_VSYNC(vs_a),
        .VGA_R(r_a), .VGA_G(g_a), .VGA_B(b_a), .FRAME_START(fs_a)
    );

    vga_ptngen_param #(
        .H_ACTIVE(320), .H_FP(8), .H_SYNC(48), .H_BP(24),
        .V_ACTIVE(240), .V_FP(4), .V_SYNC(3), .V_BP(15),
        .COLOR_W(4), .HSYNC_POL(1'b1), .VSYNC_POL(1'b0)
    ) dut_b (
        .PCK(PCK), .RST(RST), .MODE(mode_in[1]), .SCROLL_EN(scr_in[1]),
        .HCNT(hc_b), .VCNT(vc_b), .VGA_DISPLAY_EN(de_b), .VGA_HSYNC(hs_b), .VGA_VSYNC(vs_b),
        .VGA_R(r_b), .VGA_G(g_b), .VGA_B(b_b), .FRAME_START(fs_b)
    );

    vga_ptngen_param #(
        .H_ACTIVE(16), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .COLOR_W(3), .HSYNC_POL(1'b0), .VSYNC_POL(1'b1)
    ) dut_c (
        .PCK(PCK), .RST(RST), .MODE(mode_in[2]), .SCROLL_EN(scr_in[2]),
        .HCNT(hc_c), .VCNT(vc_c), .VGA_DISPLAY_EN(de_c), .VGA_HSYNC(hs_c), .VGA_VSYNC(vs_c),
        .VGA_R(r_c), .VGA_G(g_c), .VGA_B(b_c), .FRAME_START(fs_c)
    );

    initial PCK = 1'b0;
    always #5 PCK = ~PCK;

    task automatic check(input string name, input logic [31:0] act, input int expv);
        n_total++;
        if (act !== 32'(expv)) begin
            n_bad++;
            if (n_bad <= 20) $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    function automatic int h_total(cfg_t c);
        return c.ha + c.hf + c.hs + c.hb;
    endfunction

    function automatic int v_total(cfg_t c);
        return c.va + c.vf + c.vs + c.vb;
    endfunction

    // What the outputs must show for counter state n (pixel index since frame 0, pixel 0).
    function automatic exp_t model(cfg_t c, int n, int mode, int off);
        exp_t e;
        int   ht, vt, x, y, xs, mx, bar, on;
        int   rt[8];
        int   gt[8];
        int   bt[8];
        rt = '{1, 1, 0, 0, 1, 1, 0, 0};
        gt = '{1, 1, 1, 1, 0, 0, 0, 0};
        bt = '{1, 0, 1, 0, 1, 0, 1, 0};
        ht = h_total(c);
        vt = v_total(c);
        x  = n % ht;
        y  = (n / ht) % vt;
        mx = (1 << c.cw) - 1;
        xs = (x + off) % c.ha;
        e.de = (x < c.ha && y < c.va) ? 1 : 0;
        e.hs = (x >= c.ha + c.hf && x < c.ha + c.hf + c.hs) ? c.hp : 1 - c.hp;
        e.vs = (y >= c.va + c.vf && y < c.va + c.vf + c.vs) ? c.vp : 1 - c.vp;
        e.fs = (n % (ht * vt) == 0) ? 1 : 0;
        e.r = 0; e.g = 0; e.b = 0;
        case (mode)
            0: begin
                bar = xs / (c.ha / 8);
                e.r = rt[bar] * mx; e.g = gt[bar] * mx; e.b = bt[bar] * mx;
            end
            1: begin
                on  = (((xs / 32) % 2) == ((y / 32) % 2)) ? 1 : 0;
                e.r = on * mx; e.g = on * mx; e.b = on * mx;
            end
            2: begin
                e.r = xs % (mx + 1); e.g = y % (mx + 1);
            end
            3: begin
                on  = (xs % 32 == 0 || y % 32 == 0 || x == c.ha - 1 || y == c.va - 1) ? 1 : 0;
                e.r = on * mx; e.g = on * mx; e.b = on * mx;
            end
            4: e.r = mx;
            5: e.g = mx;
            6: e.b = mx;
            default: begin e.r = mx; e.g = mx; e.b = mx; end
        endcase
        if (e.de == 0) begin e.r = 0; e.g = 0; e.b = 0; end
        return e;
    endfunction

    // Frame-level record of what each frame latched: mode, scroll and the resulting offset.
    always @(posedge PCK) begin
        for (int i = 0; i < 3; i++) begin
            if (RST) begin
                k[i] = 0;
            end else begin
                int ft, f;
                ft = h_total(cfg[i]) * v_total(cfg[i]);
                if (k[i] % ft == 0) begin
                    f = k[i] / ft;
                    if (f < 256) begin
                        mode_h[i][f] = int'(mode_in[i]);
                        scr_h[i][f]  = int'(scr_in[i]);
                        off_h[i][f]  = (f == 0) ? 0 : (off_h[i][f-1] + scr_h[i][f-1]) % cfg[i].ha;
                    end
                end
                k[i]++;
            end
        end
    end

    task automatic check_inst(input int i, input logic [31:0] hc, vc, de, hs, vs, r, g, b, fs);
        cfg_t  c;
        exp_t  e;
        int    kk, ht, vt, n, f, ehc, evc;
        string t;
        c  = cfg[i];
        kk = k[i];
        ht = h_total(c);
        vt = v_total(c);
        t  = $sformatf("inst%0d k=%0d", i, kk);
        if (kk == 0) begin
            ehc = 0; evc = 0;
            e.de = 0; e.hs = 1 - c.hp; e.vs = 1 - c.vp; e.fs = 0; e.r = 0; e.g = 0; e.b = 0;
        end else begin
            n = kk - 1;
            f = n / (ht * vt);
            if (f >= 256) return;
            ehc = kk % ht;
            evc = (kk / ht) % vt;
            e = model(c, n, mode_h[i][f], off_h[i][f]);
        end
        check({t, " hcnt"}, hc, ehc);
        check({t, " vcnt"}, vc, evc);
        check({t, " de"}, de, e.de);
        check({t, " hsync"}, hs, e.hs);
        check({t, " vsync"}, vs, e.vs);
        check({t, " frame_start"}, fs, e.fs);
        check({t, " r"}, r, e.r);
        check({t, " g"}, g, e.g);
        check({t, " b"}, b, e.b);
    endtask

    always @(negedge PCK) begin
        check_inst(0, 32'(hc_a), 32'(vc_a), 32'(de_a), 32'(hs_a), 32'(vs_a),
                   32'(r_a), 32'(g_a), 32'(b_a), 32'(fs_a));
        check_inst(1, 32'(hc_b), 32'(vc_b), 32'(de_b), 32'(hs_b), 32'(vs_b),
                   32'(r_b), 32'(g_b), 32'(b_b), 32'(fs_b));
        check_inst(2, 32'(hc_c), 32'(vc_c), 32'(de_c), 32'(hs_c), 32'(vs_c),
                   32'(r_c), 32'(g_c), 32'(b_c), 32'(fs_c));
        if (!RST && k[0] > FT_A && k[0] <= 2 * FT_A) begin
            de_cnt += int'(de_a);
            hs_cnt += (hs_a == 1'b0) ? 1 : 0;
            vs_cnt += (vs_a == 1'b0) ? 1 : 0;
        end
        if (k[1] == 11)   check("B mode7 active R", 32'(r_b), 15);
        if (k[1] == 11)   check("B mode7 active B", 32'(b_b), 15);
        if (k[1] == 328)  check("B hsync before window", 32'(hs_b), 0);
        if (k[1] == 329)  check("B hsync active-high", 32'(hs_b), 1);
        if (k[1] == 1131) check("B blank R", 32'(r_b), 0);
        if (k[2] == 141)  check("C frame1 x0 white", 32'({r_c, g_c, b_c}), 9'h1FF);
        if (k[2] == 142)  check("C frame1 x1 yellow", 32'({r_c, g_c, b_c}), 9'h1F8);
        if (k[2] == 2101) check("C frame15 x0 black", 32'({r_c, g_c, b_c}), 0);
        if (k[2] == 2241) check("C frame16 offset wrapped", 32'({r_c, g_c, b_c}), 9'h1FF);
    end

    task automatic wait_a(input int h, input int v);
        int t;
        t = 0;
        do begin
            @(negedge PCK);
            t++;
        end while (!(hc_a == 10'(h) && vc_a == 10'(v)) && t < 20000);
        if (t >= 20000) check($sformatf("timeout waiting for A at (%0d,%0d)", h, v), 0, 1);
    endtask

    task automatic chk_rgb_a(input string name, input int r, input int g, input int b);
        check({name, " R"}, 32'(r_a), r);
        check({name, " G"}, 32'(g_a), g);
        check({name, " B"}, 32'(b_a), b);
    endtask

    initial begin
        cfg[0] = '{64, 4, 8, 4, 40, 2, 2, 4, 8, 0, 0};
        cfg[1] = '{320, 8, 48, 24, 240, 4, 3, 15, 4, 1, 0};
        cfg[2] = '{16, 1, 2, 1, 4, 1, 1, 1, 3, 0, 1};
        for (int i = 0; i < 3; i++) k[i] = 0;
        RST = 1'b1;
        mode_in[0] = 3'd0; scr_in[0] = 1'b0;
        mode_in[1] = 3'd7; scr_in[1] = 1'b0;
        mode_in[2] = 3'd0; scr_in[2] = 1'b1;
        repeat (3) @(negedge PCK);
        check("reset A hsync idle high", 32'(hs_a), 1);
        check("reset B hsync idle low", 32'(hs_b), 0);
        check("reset C vsync idle low", 32'(vs_c), 0);
        RST = 1'b0;

        wait_a(30, 0);
        check("A de before mid-line reset", 32'(de_a), 1);
        #2 RST = 1'b1;
        #1;
        check("async reset hcnt", 32'(hc_a), 0);
        check("async reset de", 32'(de_a), 0);
        check("async reset hsync", 32'(hs_a), 1);
        check("async reset vsync", 32'(vs_a), 1);
        check("async reset rgb", 32'({r_a, g_a, b_a}), 0);
        check("async reset frame_start", 32'(fs_a), 0);
        check("async reset B hsync", 32'(hs_b), 0);
        @(negedge PCK);
        @(negedge PCK);
        RST = 1'b0;

        @(negedge PCK);
        check("restart hcnt=1", 32'(hc_a), 1);
        check("restart frame_start high", 32'(fs_a), 1);
        chk_rgb_a("mode0 x=0", 255, 255, 255);
        @(negedge PCK);
        check("restart hcnt=2", 32'(hc_a), 2);
        check("frame_start one cycle", 32'(fs_a), 0);

        wait_a(9, 0);  chk_rgb_a("mode0 x=8", 255, 255, 0);
        wait_a(64, 0); chk_rgb_a("mode0 x=63", 0, 0, 0);
        wait_a(68, 0); check("hsync idle x=67", 32'(hs_a), 1);
        wait_a(69, 0); check("hsync active x=68", 32'(hs_a), 0);
        wait_a(71, 0); chk_rgb_a("blank x=70", 0, 0, 0);
        check("blank de", 32'(de_a), 0);

        wait_a(0, 10); mode_in[0] = 3'd4;
        wait_a(9, 20); chk_rgb_a("mode held mid-frame", 255, 255, 0);
        wait_a(0, 42); check("vsync idle line 41", 32'(vs_a), 1);
        wait_a(1, 42); check("vsync active line 42", 32'(vs_a), 0);
        wait_a(6, 5);  chk_rgb_a("mode4 next frame", 255, 0, 0);

        mode_in[0] = 3'd1; scr_in[0] = 1'b1;
        wait_a(32, 0); chk_rgb_a("checker frame2 x=31", 255, 255, 255);
        wait_a(32, 0); chk_rgb_a("checker frame3 x=31", 0, 0, 0);
        wait_a(31, 0); chk_rgb_a("checker frame4 x=30", 0, 0, 0);
        wait_a(0, 1);  scr_in[0] = 1'b0;
        wait_a(29, 0); chk_rgb_a("checker frame5 x=28", 255, 255, 255);
        wait_a(30, 0); chk_rgb_a("checker frame5 x=29", 0, 0, 0);

        mode_in[0] = 3'd2;
        wait_a(11, 0); chk_rgb_a("ramp frame6 x=10", 13, 0, 0);
        wait_a(0, 1);  mode_in[0] = 3'd3;
        wait_a(30, 0); chk_rgb_a("hatch frame7 x=29", 255, 255, 255);
        wait_a(2, 1);  chk_rgb_a("hatch frame7 (1,1)", 0, 0, 0);
        wait_a(0, 2);  mode_in[0] = 3'd6;

        for (int t = 0; t < 40000 && k[0] < 9 * FT_A + 2; t++) @(negedge PCK);
        check("end of run reached", 32'(k[0] >= 9 * FT_A + 2), 1);
        check("display_en per frame", 32'(de_cnt), 2560);
        check("hsync low per frame", 32'(hs_cnt), 384);
        check("vsync low per frame", 32'(vs_cnt), 160);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
